// File: rtl/cfg_spi_pkg.sv
// Shared widths, FSM state type and address-window helper for the config SPI responder.
package cfg_spi_pkg;

  localparam int unsigned FRAME_W = 32;
  localparam int unsigned ADDR_W  = 15;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned CNT_W   = 6;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    DATA,
    WAIT_SS_HIGH
  } cfg_spi_state_t;

  // 16-bit window compare so BASE+SPAN never wraps back into low addresses
  function automatic logic addr_hit(input logic [ADDR_W-1:0] addr,
                                    input logic [ADDR_W-1:0] base,
                                    input logic [15:0]       span);
    logic [15:0] lo;
    logic [15:0] hi;
    lo = {1'b0, base};
    hi = lo + span;
    return ({1'b0, addr} >= lo) && ({1'b0, addr} < hi);
  endfunction

endpackage

// File: rtl/cfg_spi_responder_sync.sv
// Oversampling front end: synchronizes sclk/ss_n/mosi and detects sclk edges and ss_n fall.
module spi_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic i_reset,
  input  logic i_sclk,
  input  logic i_ss_n,
  input  logic i_mosi,
  output logic o_sclk_rise_c,
  output logic o_sclk_fall_c,
  output logic o_ss_fall_c,
  output logic o_ss_n,
  output logic o_mosi
);

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_ss_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sclk_prev;
  logic                   r_ss_prev;

  // ss_n resets to 0 so a select held low across reset is never seen as a fresh fall
  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_sclk_sync <= '0;
      r_ss_sync   <= '0;
      r_mosi_sync <= '0;
      r_sclk_prev <= 1'b0;
      r_ss_prev   <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
      r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], i_ss_n};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
      r_sclk_prev <= r_sclk_sync[SYNC_STAGES-1];
      r_ss_prev   <= r_ss_sync[SYNC_STAGES-1];
    end
  end

  assign o_sclk_rise_c = r_sclk_sync[SYNC_STAGES-1] & ~r_sclk_prev;
  assign o_sclk_fall_c = ~r_sclk_sync[SYNC_STAGES-1] & r_sclk_prev;
  assign o_ss_fall_c   = ~r_ss_sync[SYNC_STAGES-1] & r_ss_prev;
  assign o_ss_n        = r_ss_sync[SYNC_STAGES-1];
  assign o_mosi        = r_mosi_sync[SYNC_STAGES-1];

endmodule

// File: rtl/cfg_spi_responder.sv
// SPI mode-0 slave turning 32-bit frames into register-bus read/write strobes.
module cfg_spi_responder
  import cfg_spi_pkg::*;
#(
  parameter logic [14:0] BASE_ADDR   = 15'h0000,
  parameter int unsigned ADDR_SPAN   = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spi_sclk,
  input  logic              spi_ss_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              reg_wr,
  output logic              reg_rd,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic              frame_err
);

  localparam logic [15:0] SPAN16 = 16'(ADDR_SPAN);

  logic w_rise;
  logic w_fall;
  logic w_ss_fall;
  logic w_ss_n;
  logic w_mosi;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk           (clk),
    .i_reset       (reset),
    .i_sclk        (spi_sclk),
    .i_ss_n        (spi_ss_n),
    .i_mosi        (spi_mosi),
    .o_sclk_rise_c (w_rise),
    .o_sclk_fall_c (w_fall),
    .o_ss_fall_c   (w_ss_fall),
    .o_ss_n        (w_ss_n),
    .o_mosi        (w_mosi)
  );

  cfg_spi_state_t    r_state;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [14:0]       r_rx;
  logic [DATA_W-1:0] r_tx;
  logic              r_rw;
  logic              r_hit;
  logic              r_miso;
  logic              r_oe;
  logic [ADDR_W-1:0] r_reg_addr;
  logic [DATA_W-1:0] r_reg_wdata;
  logic              r_reg_wr;
  logic              r_reg_rd;
  logic              r_frame_err;

  // Last 16 received bits including the one arriving on this rise
  logic [15:0] w_word;
  logic        w_hit;
  assign w_word = {r_rx, w_mosi};
  assign w_hit  = addr_hit(w_word[14:0], BASE_ADDR, SPAN16);

  // Frame FSM with bit counting, shift registers and registered bus strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_bit_cnt   <= '0;
      r_rx        <= '0;
      r_tx        <= '0;
      r_rw        <= 1'b0;
      r_hit       <= 1'b0;
      r_miso      <= 1'b0;
      r_oe        <= 1'b0;
      r_reg_addr  <= '0;
      r_reg_wdata <= '0;
      r_reg_wr    <= 1'b0;
      r_reg_rd    <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_reg_wr    <= 1'b0;
      r_reg_rd    <= 1'b0;
      r_frame_err <= 1'b0;
      if (r_reg_rd) begin
        r_tx <= reg_rdata;
      end
      case (r_state)
        IDLE: begin
          r_oe   <= 1'b0;
          r_miso <= 1'b0;
          if (w_ss_fall) begin
            r_state   <= HDR;
            r_bit_cnt <= '0;
            r_rx      <= '0;
          end else if (!w_ss_n) begin
            // select already low without a visible fall: sit out this frame
            r_state <= WAIT_SS_HIGH;
          end
        end
        HDR, DATA: begin
          if (w_ss_n) begin
            r_state     <= IDLE;
            r_frame_err <= 1'b1;
            r_oe        <= 1'b0;
            r_miso      <= 1'b0;
          end else if (w_rise) begin
            r_rx      <= w_word[14:0];
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            if (r_state == HDR && r_bit_cnt == CNT_W'(15)) begin
              r_state    <= DATA;
              r_rw       <= w_word[15];
              r_hit      <= w_hit;
              r_reg_addr <= w_word[14:0];
              if (!w_word[15] && w_hit) begin
                r_reg_rd <= 1'b1;
                r_oe     <= 1'b1;
              end
            end else if (r_state == DATA && r_bit_cnt == CNT_W'(31)) begin
              r_state <= WAIT_SS_HIGH;
              r_oe    <= 1'b0;
              r_miso  <= 1'b0;
              if (r_rw && r_hit) begin
                r_reg_wdata <= w_word;
                r_reg_wr    <= 1'b1;
              end
            end
          end else if (w_fall && r_state == DATA && r_oe) begin
            r_miso <= r_tx[DATA_W-1];
            r_tx   <= {r_tx[DATA_W-2:0], 1'b0};
          end
        end
        WAIT_SS_HIGH: begin
          r_oe   <= 1'b0;
          r_miso <= 1'b0;
          if (w_ss_n) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign spi_miso    = r_miso;
  assign spi_miso_oe = r_oe;
  assign reg_addr    = r_reg_addr;
  assign reg_wdata   = r_reg_wdata;
  assign reg_wr      = r_reg_wr;
  assign reg_rd      = r_reg_rd;
  assign frame_err   = r_frame_err;

endmodule

// File: tb/tb_cfg_spi_responder.sv
// Self-checking bench: two responders (BASE 0/SPAN 32 and BASE 0x10/SPAN 4) on one SPI bus.
`timescale 1ns/1ps
module tb_cfg_spi_responder;

  localparam int H = 50;  // SCLK half period; clk period is 10 ns, so clk = 10x SCLK

  logic        clk = 1'b0;
  logic        reset;
  logic        sclk;
  logic        ss_n;
  logic        mosi;
  logic        miso  [2];
  logic        oe    [2];
  logic        wr    [2];
  logic        rd    [2];
  logic        err   [2];
  logic [14:0] addr  [2];
  logic [15:0] wdata [2];
  logic [15:0] rdata [2];

  int unsigned m_base [2] = '{0, 16};
  int unsigned m_span [2] = '{32, 4};

  int n_vec = 0;
  int n_err = 0;

  int          wr_cnt [2];
  int          rd_cnt [2];
  int          err_cnt [2];
  int          both_cnt [2];
  int          bad_miso [2];
  logic [14:0] wr_addr [2];
  logic [15:0] wr_data [2];
  logic [14:0] rd_addr [2];

  int          d_wr [2];
  int          d_rd [2];
  int          d_err [2];
  logic [15:0] miso_word [2];
  logic [63:0] oe_bits [2];

  always #5 clk = ~clk;

  cfg_spi_responder #(.BASE_ADDR(15'h0000), .ADDR_SPAN(32), .SYNC_STAGES(2)) u_dut0 (
    .clk(clk), .reset(reset), .spi_sclk(sclk), .spi_ss_n(ss_n), .spi_mosi(mosi),
    .spi_miso(miso[0]), .spi_miso_oe(oe[0]), .reg_addr(addr[0]), .reg_wdata(wdata[0]),
    .reg_wr(wr[0]), .reg_rd(rd[0]), .reg_rdata(rdata[0]), .frame_err(err[0]));

  cfg_spi_responder #(.BASE_ADDR(15'h0010), .ADDR_SPAN(4), .SYNC_STAGES(2)) u_dut1 (
    .clk(clk), .reset(reset), .spi_sclk(sclk), .spi_ss_n(ss_n), .spi_mosi(mosi),
    .spi_miso(miso[1]), .spi_miso_oe(oe[1]), .reg_addr(addr[1]), .reg_wdata(wdata[1]),
    .reg_wr(wr[1]), .reg_rd(rd[1]), .reg_rdata(rdata[1]), .frame_err(err[1]));

  // Strobe monitor, sampled on the inactive edge
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (wr[k]) begin
        wr_cnt[k]  <= wr_cnt[k] + 1;
        wr_addr[k] <= addr[k];
        wr_data[k] <= wdata[k];
      end
      if (rd[k]) begin
        rd_cnt[k]  <= rd_cnt[k] + 1;
        rd_addr[k] <= addr[k];
      end
      if (err[k]) err_cnt[k] <= err_cnt[k] + 1;
      if (wr[k] && rd[k]) both_cnt[k] <= both_cnt[k] + 1;
      if (!oe[k] && miso[k]) bad_miso[k] <= bad_miso[k] + 1;
    end
  end

  // Reference model: what a frame should do to responder k
  task automatic model(input logic [31:0] f, input int k, input logic [15:0] rdv,
                       output int e_wr, output int e_rd, output logic [15:0] e_miso,
                       output logic [63:0] e_oe);
    int unsigned a;
    bit hit;
    a   = int'(f[30:16]);
    hit = (a >= m_base[k]) && (a < m_base[k] + m_span[k]);
    e_wr   = (f[31] && hit) ? 1 : 0;
    e_rd   = (!f[31] && hit) ? 1 : 0;
    e_miso = (e_rd != 0) ? rdv : 16'h0000;
    e_oe   = (e_rd != 0) ? 64'h0000_0000_FFFF_0000 : 64'h0;
  endtask

  // Master: one frame of nbits SCLK cycles, then ss_n high and the minimum idle gap
  task automatic run_frame(input logic [31:0] f, input int nbits);
    int s_wr [2];
    int s_rd [2];
    int s_err [2];
    for (int k = 0; k < 2; k++) begin
      s_wr[k] = wr_cnt[k]; s_rd[k] = rd_cnt[k]; s_err[k] = err_cnt[k];
      miso_word[k] = 16'h0; oe_bits[k] = 64'h0;
    end
    ss_n = 1'b0;
    #(H);
    for (int i = 0; i < nbits; i++) begin
      mosi = (i < 32) ? f[31-i] : 1'($urandom_range(0, 1));
      #(H);
      for (int k = 0; k < 2; k++) begin
        oe_bits[k][i] = oe[k];
        if (i >= 16 && i < 32) miso_word[k] = {miso_word[k][14:0], miso[k]};
      end
      sclk = 1'b1;
      #(H);
      sclk = 1'b0;
    end
    #(H);
    ss_n = 1'b1;
    #(4*H);
    for (int k = 0; k < 2; k++) begin
      d_wr[k] = wr_cnt[k] - s_wr[k]; d_rd[k] = rd_cnt[k] - s_rd[k]; d_err[k] = err_cnt[k] - s_err[k];
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; sclk = 1'b0; ss_n = 1'b1; mosi = 1'b0;
    rdata[0] = 16'h0; rdata[1] = 16'h0;
    #2;
    repeat (4) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      n_vec++;
      if ({wr[k], rd[k], err[k], oe[k], miso[k]} !== 5'b0) begin
        n_err++; $display("FAIL reset_strobes dut%0d: got %b want 00000", k, {wr[k], rd[k], err[k], oe[k], miso[k]});
      end
      n_vec++;
      if ({addr[k], wdata[k]} !== 31'h0) begin
        n_err++; $display("FAIL reset_bus dut%0d: got addr %h wdata %h want 0", k, addr[k], wdata[k]);
      end
    end
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #2;
  endtask

  task automatic test_write();
    run_frame(32'h8005_1234, 32);
    n_vec++;
    if (d_wr[0] !== 1 || d_rd[0] !== 0) begin
      n_err++; $display("FAIL write_strobe: got wr %0d rd %0d want wr 1 rd 0", d_wr[0], d_rd[0]);
    end
    n_vec++;
    if (wr_addr[0] !== 15'h0005 || wr_data[0] !== 16'h1234) begin
      n_err++; $display("FAIL write_bus: got addr %h data %h want 0005 1234", wr_addr[0], wr_data[0]);
    end
    n_vec++;
    if (d_wr[1] !== 0 || d_rd[1] !== 0) begin
      n_err++; $display("FAIL write_miss_dut1: got wr %0d rd %0d want 0 0", d_wr[1], d_rd[1]);
    end
  endtask

  task automatic test_read();
    rdata[0] = 16'hBEEF; rdata[1] = 16'h5A5A;
    run_frame(32'h0002_0000, 32);
    n_vec++;
    if (d_rd[0] !== 1 || d_wr[0] !== 0 || rd_addr[0] !== 15'h0002) begin
      n_err++; $display("FAIL read_strobe: got rd %0d wr %0d addr %h want 1 0 0002", d_rd[0], d_wr[0], rd_addr[0]);
    end
    n_vec++;
    if (miso_word[0] !== 16'hBEEF) begin
      n_err++; $display("FAIL read_miso: got %h want beef", miso_word[0]);
    end
    n_vec++;
    if (oe_bits[0] !== 64'h0000_0000_FFFF_0000) begin
      n_err++; $display("FAIL read_oe: got %h want 00000000ffff0000", oe_bits[0]);
    end
    n_vec++;
    if (d_rd[1] !== 0 || oe_bits[1] !== 64'h0) begin
      n_err++; $display("FAIL read_miss_dut1: got rd %0d oe %h want 0 0", d_rd[1], oe_bits[1]);
    end
  endtask

  task automatic test_abort();
    run_frame(32'h8003_5555, 20);
    for (int k = 0; k < 2; k++) begin
      n_vec++;
      if (d_err[k] !== 1 || d_wr[k] !== 0 || d_rd[k] !== 0) begin
        n_err++; $display("FAIL abort dut%0d: got err %0d wr %0d rd %0d want 1 0 0", k, d_err[k], d_wr[k], d_rd[k]);
      end
    end
    run_frame(32'h8011_ABCD, 32);
    for (int k = 0; k < 2; k++) begin
      n_vec++;
      if (d_wr[k] !== 1 || d_err[k] !== 0 || wr_addr[k] !== 15'h0011 || wr_data[k] !== 16'hABCD) begin
        n_err++; $display("FAIL after_abort dut%0d: got wr %0d err %0d addr %h data %h want 1 0 0011 abcd",
                          k, d_wr[k], d_err[k], wr_addr[k], wr_data[k]);
      end
    end
  endtask

  task automatic test_window();
    run_frame(32'h8014_7777, 32);
    n_vec++;
    if (d_wr[1] !== 0 || d_rd[1] !== 0 || d_err[1] !== 0) begin
      n_err++; $display("FAIL win_above: got wr %0d rd %0d err %0d want 0 0 0", d_wr[1], d_rd[1], d_err[1]);
    end
    rdata[1] = 16'hFFFF;
    run_frame(32'h000F_0000, 32);
    n_vec++;
    if (d_rd[1] !== 0 || oe_bits[1] !== 64'h0 || d_err[1] !== 0) begin
      n_err++; $display("FAIL win_below: got rd %0d oe %h err %0d want 0 0 0", d_rd[1], oe_bits[1], d_err[1]);
    end
    run_frame(32'h8013_0F0F, 32);
    n_vec++;
    if (d_wr[1] !== 1 || wr_addr[1] !== 15'h0013 || wr_data[1] !== 16'h0F0F) begin
      n_err++; $display("FAIL win_top: got wr %0d addr %h data %h want 1 0013 0f0f", d_wr[1], wr_addr[1], wr_data[1]);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] f;
    int s_wr [2];
    int s_rd [2];
    f = 32'h8012_3C3C;
    for (int k = 0; k < 2; k++) begin s_wr[k] = wr_cnt[k]; s_rd[k] = rd_cnt[k]; end
    ss_n = 1'b0;
    #(H);
    for (int i = 0; i < 24; i++) begin
      mosi = f[31-i]; #(H); sclk = 1'b1; #(H); sclk = 1'b0;
    end
    @(posedge clk);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      n_vec++;
      if ({wr[k], rd[k], err[k], oe[k], miso[k]} !== 5'b0 || {addr[k], wdata[k]} !== 31'h0) begin
        n_err++; $display("FAIL midreset_out dut%0d: got flags %b addr %h want 0 0", k,
                          {wr[k], rd[k], err[k], oe[k], miso[k]}, addr[k]);
      end
    end
    reset = 1'b0;
    for (int i = 24; i < 32; i++) begin
      mosi = f[31-i]; #(H); sclk = 1'b1; #(H); sclk = 1'b0;
    end
    #(H);
    ss_n = 1'b1;
    #(4*H);
    for (int k = 0; k < 2; k++) begin
      n_vec++;
      if (wr_cnt[k] - s_wr[k] !== 0 || rd_cnt[k] - s_rd[k] !== 0) begin
        n_err++; $display("FAIL midreset_strobe dut%0d: got wr %0d rd %0d want 0 0", k,
                          wr_cnt[k] - s_wr[k], rd_cnt[k] - s_rd[k]);
      end
    end
    run_frame(32'h8012_C3C3, 32);
    for (int k = 0; k < 2; k++) begin
      n_vec++;
      if (d_wr[k] !== 1 || wr_data[k] !== 16'hC3C3) begin
        n_err++; $display("FAIL midreset_next dut%0d: got wr %0d data %h want 1 c3c3", k, d_wr[k], wr_data[k]);
      end
    end
  endtask

  task automatic test_long_frame();
    run_frame(32'h8001_4242, 40);
    n_vec++;
    if (d_wr[0] !== 1 || d_err[0] !== 0 || wr_data[0] !== 16'h4242 || wr_addr[0] !== 15'h0001) begin
      n_err++; $display("FAIL long_frame: got wr %0d err %0d addr %h data %h want 1 0 0001 4242",
                        d_wr[0], d_err[0], wr_addr[0], wr_data[0]);
    end
  endtask

  task automatic test_back_to_back();
    run_frame(32'h801F_1111, 32);
    n_vec++;
    if (d_wr[0] !== 1 || wr_addr[0] !== 15'h001F || wr_data[0] !== 16'h1111) begin
      n_err++; $display("FAIL b2b_first: got wr %0d addr %h data %h want 1 001f 1111", d_wr[0], wr_addr[0], wr_data[0]);
    end
    rdata[0] = 16'h8001;
    run_frame(32'h0000_0000, 32);
    n_vec++;
    if (d_rd[0] !== 1 || miso_word[0] !== 16'h8001) begin
      n_err++; $display("FAIL b2b_second: got rd %0d miso %h want 1 8001", d_rd[0], miso_word[0]);
    end
  endtask

  task automatic test_random();
    logic [31:0] f;
    logic [14:0] a;
    int          e_wr, e_rd;
    logic [15:0] e_miso;
    logic [63:0] e_oe;
    for (int n = 0; n < 12; n++) begin
      a = ($urandom_range(0, 7) == 0) ? 15'($urandom) : 15'($urandom_range(0, 40));
      f = {1'($urandom_range(0, 1)), a, 16'($urandom)};
      rdata[0] = 16'($urandom); rdata[1] = 16'($urandom);
      run_frame(f, 32);
      for (int k = 0; k < 2; k++) begin
        model(f, k, rdata[k], e_wr, e_rd, e_miso, e_oe);
        n_vec++;
        if (d_wr[k] !== e_wr || d_rd[k] !== e_rd || d_err[k] !== 0) begin
          n_err++; $display("FAIL rand_strobe dut%0d f=%h: got wr %0d rd %0d err %0d want %0d %0d 0",
                            k, f, d_wr[k], d_rd[k], d_err[k], e_wr, e_rd);
        end
        n_vec++;
        if (oe_bits[k] !== e_oe || (e_rd != 0 && miso_word[k] !== e_miso)) begin
          n_err++; $display("FAIL rand_miso dut%0d f=%h: got oe %h miso %h want %h %h",
                            k, f, oe_bits[k], miso_word[k], e_oe, e_miso);
        end
        if (e_wr != 0) begin
          n_vec++;
          if (wr_addr[k] !== f[30:16] || wr_data[k] !== f[15:0]) begin
            n_err++; $display("FAIL rand_wbus dut%0d: got %h %h want %h %h", k, wr_addr[k], wr_data[k], f[30:16], f[15:0]);
          end
        end
        if (e_rd != 0) begin
          n_vec++;
          if (rd_addr[k] !== f[30:16]) begin
            n_err++; $display("FAIL rand_raddr dut%0d: got %h want %h", k, rd_addr[k], f[30:16]);
          end
        end
      end
    end
    for (int k = 0; k < 2; k++) begin
      n_vec++;
      if (both_cnt[k] !== 0 || bad_miso[k] !== 0) begin
        n_err++; $display("FAIL invariants dut%0d: got both %0d miso_undriven %0d want 0 0", k, both_cnt[k], bad_miso[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_abort();
    test_window();
    test_reset_mid();
    test_long_frame();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
